// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types for the memory-port round-robin arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Widest address/data the registered request copy can hold.
    localparam int c_mem_addr_w = 64;
    localparam int c_mem_data_w = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                    write;
        logic [c_mem_addr_w-1:0] addr;
        logic [c_mem_data_w-1:0] wdata;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Rotating-priority first-one finder starting at rr_ptr.
//  Revision : 1.0  initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    localparam logic [IDX_W:0] c_num = (IDX_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W:0]       w_sum;

    // Rotate so that bit 0 is the requester at rr_ptr.
    assign w_dbl = {req, req};
    assign w_rot = NUM_REQ'(w_dbl >> rr_ptr);

    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign w_sum = {1'b0, rr_ptr} + {1'b0, w_off};
    assign valid = |req;
    assign index = (w_sum >= c_num) ? IDX_W'(w_sum - c_num) : IDX_W'(w_sum);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter sharing one memory controller port among
//             NUM_CORES requesters. Define ARB_LOCK_EN to enable grant
//             retention across atomic sequences (bounded by LOCK_MAX).
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LOCK_MAX   = 16
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [NUM_CORES-1:0]                                core_req,
    input  logic [NUM_CORES-1:0]                                core_write,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]                     core_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]                     core_wdata,
    input  logic [NUM_CORES-1:0]                                core_lock,
    output logic [NUM_CORES-1:0]                                core_ready,
    output logic [DATA_WIDTH-1:0]                               core_rdata,
    output logic                                                mem_req,
    output logic                                                mem_write,
    output logic [ADDR_WIDTH-1:0]                               mem_addr,
    output logic [DATA_WIDTH-1:0]                               mem_wdata,
    input  logic [DATA_WIDTH-1:0]                               mem_rdata,
    input  logic                                                mem_ready,
    output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] grant_id,
    output logic                                                busy
);

    localparam int              c_id_w = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [c_id_w-1:0] c_last = c_id_w'(NUM_CORES - 1);

    arb_state_e          r_state;
    mem_req_t            r_req;
    logic [c_id_w-1:0]   r_rr_ptr;
    logic                w_valid;
    logic [c_id_w-1:0]   w_idx;
    logic [c_id_w-1:0]   w_next_ptr;

    logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_CORES];
    logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign w_addr_arr[g]  = core_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[g] = core_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_picker #(
        .NUM_REQ (NUM_CORES),
        .IDX_W   (c_id_w)
    ) u_picker (
        .req    (core_req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_valid),
        .index  (w_idx)
    );

    assign w_next_ptr = (grant_id == c_last) ? '0 : grant_id + c_id_w'(1);

`ifdef ARB_LOCK_EN
    localparam int                  c_lock_w    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [c_lock_w-1:0] c_lock_last = c_lock_w'(LOCK_MAX - 1);

    logic [c_lock_w-1:0] r_lock_cnt;
    logic                w_hold;

    assign w_hold = core_lock[grant_id] && (r_lock_cnt < c_lock_last);
`else
    localparam int c_unused_lock_max = LOCK_MAX;
    logic          w_unused_lock;

    assign w_unused_lock = ^core_lock;
`endif

    // Downstream fields come only from the registered copy, never the cores.
    assign mem_write = r_req.write;
    assign mem_addr  = ADDR_WIDTH'(r_req.addr);
    assign mem_wdata = DATA_WIDTH'(r_req.wdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_rr_ptr   <= '0;
            mem_req    <= 1'b0;
            core_ready <= '0;
            core_rdata <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
`ifdef ARB_LOCK_EN
            r_lock_cnt <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        grant_id    <= w_idx;
                        r_req.write <= core_write[w_idx];
                        r_req.addr  <= c_mem_addr_w'(w_addr_arr[w_idx]);
                        r_req.wdata <= c_mem_data_w'(w_wdata_arr[w_idx]);
                        mem_req     <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= ISSUE;
`ifdef ARB_LOCK_EN
                        if (w_idx != grant_id) begin
                            r_lock_cnt <= '0;
                        end
`endif
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        core_ready <= NUM_CORES'(1) << grant_id;
                        core_rdata <= r_req.write ? '0 : mem_rdata;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    core_ready <= '0;
                    busy       <= 1'b0;
                    r_state    <= IDLE;
`ifdef ARB_LOCK_EN
                    if (w_hold) begin
                        r_rr_ptr   <= grant_id;
                        r_lock_cnt <= r_lock_cnt + c_lock_w'(1);
                    end else begin
                        r_rr_ptr   <= w_next_ptr;
                        r_lock_cnt <= '0;
                    end
`else
                    r_rr_ptr <= w_next_ptr;
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter against a transaction model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LM = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    core_req, core_write, core_lock, core_ready;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [DW-1:0]   core_rdata, mem_wdata, mem_rdata;
    logic            mem_req, mem_write, mem_ready, busy;
    logic [AW-1:0]   mem_addr;
    logic [1:0]      grant_id;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;
    int m_cnt = 0;
    int m_last = 0;

    mem_arbiter #(
        .NUM_CORES  (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LOCK_MAX   (LM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_write (core_write),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_lock  (core_lock),
        .core_ready (core_ready),
        .core_rdata (core_rdata),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester at or after ptr, wrapping; -1 when none.
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (r[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic set_core(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_write[c]          = w;
        core_addr[c*AW +: AW]  = a;
        core_wdata[c*DW +: DW] = d;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_cnt  = 0;
        m_last = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        core_req  = '0;
        core_lock = '0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One full transaction from an IDLE negedge back to the next IDLE negedge.
    task automatic do_txn(input int w, input logic [DW-1:0] rd, input bit drop,
                          input bit release_req, output int obs_g);
        int            g;
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        obs_g = -1;
        g = pick(core_req, m_ptr);
        if (g < 0) begin
            @(negedge clk);
            check("idle_mem_req", {63'd0, mem_req}, 64'd0);
            check("idle_busy", {63'd0, busy}, 64'd0);
            return;
        end
        if (g != m_last) m_cnt = 0;
        ew = core_write[g];
        ea = core_addr[g*AW +: AW];
        ed = core_wdata[g*DW +: DW];
        @(negedge clk);
        obs_g = int'(grant_id);
        check("grant_id", 64'(grant_id), 64'(g));
        check("issue_mem_req", {63'd0, mem_req}, 64'd1);
        check("issue_busy", {63'd0, busy}, 64'd1);
        check("issue_ready", 64'(core_ready), 64'd0);
        check("mem_addr", mem_addr, ea);
        check("mem_write", {63'd0, mem_write}, {63'd0, ew});
        check("mem_wdata", mem_wdata, ed);
        if (drop) core_req[g] = 1'b0;
        for (int c = 0; c < N; c++) begin
            set_core(c, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        end
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            check("wait_mem_req", {63'd0, mem_req}, 64'd1);
            check("wait_mem_addr", mem_addr, ea);
            check("wait_mem_wdata", mem_wdata, ed);
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        check("core_ready", 64'(core_ready), 64'(1) << g);
        check("core_rdata", core_rdata, ew ? 64'd0 : rd);
        check("resp_mem_req", {63'd0, mem_req}, 64'd0);
        // Stray completion in RESP must have no effect.
        mem_rdata = ~rd;
        if (release_req) core_req[g] = 1'b0;
        @(negedge clk);
        check("idle_core_ready", 64'(core_ready), 64'd0);
        check("idle_busy_after", {63'd0, busy}, 64'd0);
        mem_ready = 1'b0;
        m_last = g;
`ifdef ARB_LOCK_EN
        if (core_lock[g] && m_cnt < LM - 1) begin
            m_ptr = g;
            m_cnt++;
        end else begin
            m_ptr = (g + 1) % N;
            m_cnt = 0;
        end
`else
        m_ptr = (g + 1) % N;
`endif
    endtask

    initial begin
        int og;
        int exp_rr[5];
        int exp_lk[5];
        logic [N-1:0] nreq;

        rst        = 1'b1;
        core_req   = '0;
        core_write = '0;
        core_addr  = '0;
        core_wdata = '0;
        core_lock  = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_core_ready", 64'(core_ready), 64'd0);
        check("rst_core_rdata", core_rdata, 64'd0);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_write", {63'd0, mem_write}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        model_reset();

        // Single read from core 2 with two wait cycles.
        set_core(2, 1'b0, 64'h0000_0000_8000_0010, 64'd0);
        core_req = 4'b0100;
        do_txn(2, 64'h1122_3344_5566_7788, 1'b0, 1'b1, og);
        check("single_grant", 64'(og), 64'd2);

        // All cores requesting continuously from reset.
        do_reset();
        exp_rr = '{0, 1, 2, 3, 0};
        for (int c = 0; c < N; c++) set_core(c, 1'b0, 64'(c) << 8, 64'd0);
        core_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            do_txn(0, {$urandom, $urandom}, 1'b0, 1'b0, og);
            check("rr_order", 64'(og), 64'(exp_rr[i]));
        end

        // Core 1 write, request dropped while in flight.
        do_reset();
        set_core(1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_CAFE);
        core_req = 4'b0010;
        do_txn(3, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0, og);
        check("drop_grant", 64'(og), 64'd1);
        core_req = 4'b0101;
        do_txn(1, 64'h55, 1'b0, 1'b1, og);
        check("after_drop_grant", 64'(og), 64'd2);
        core_req = '0;

        // Reset while ISSUE is waiting on a slow completion.
        set_core(3, 1'b1, 64'hABCD_0000_1234_5678, 64'h0F0F_0F0F_0F0F_0F0F);
        core_req = 4'b1000;
        @(negedge clk);
        check("pre_rst_mem_req", {63'd0, mem_req}, 64'd1);
        check("pre_rst_grant", 64'(grant_id), 64'd3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_mem_req", {63'd0, mem_req}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_grant", 64'(grant_id), 64'd0);
        check("midrst_mem_addr", mem_addr, 64'd0);
        check("midrst_mem_wdata", mem_wdata, 64'd0);
        check("midrst_mem_write", {63'd0, mem_write}, 64'd0);
        check("midrst_ready", 64'(core_ready), 64'd0);
        rst       = 1'b0;
        core_req  = '0;
        mem_ready = 1'b1;
        mem_rdata = 64'h1234;
        model_reset();
        @(negedge clk);
        check("late_ready_core_ready", 64'(core_ready), 64'd0);
        check("late_ready_mem_req", {63'd0, mem_req}, 64'd0);
        check("late_ready_busy", {63'd0, busy}, 64'd0);
        mem_ready = 1'b0;

        // Core 0 holds lock while cores 0 and 1 request.
        do_reset();
`ifdef ARB_LOCK_EN
        exp_lk = '{0, 0, 0, 0, 1};
`else
        exp_lk = '{0, 1, 0, 1, 0};
`endif
        core_lock = 4'b0001;
        core_req  = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            do_txn(0, {$urandom, $urandom}, 1'b0, 1'b0, og);
            check("lock_order", 64'(og), 64'(exp_lk[i]));
        end

        // Randomized traffic against the model.
        do_reset();
        for (int it = 0; it < 40; it++) begin
            nreq = N'($urandom) & ~core_req;
            for (int c = 0; c < N; c++) begin
                if (nreq[c]) set_core(c, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            end
            core_req  = core_req | nreq;
            core_lock = N'($urandom);
            do_txn(int'($urandom_range(0, 3)), {$urandom, $urandom},
                   ($urandom_range(0, 7) == 0), 1'b1, og);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
